// File: rtl/msp_trace_pkg.sv
// Shared definitions for the openMSP430 instruction trace buffer.
// Optional macro MSP_TRACE_CYCLE_EN adds a cycle-count field on top of each entry.
`ifndef MSP_TRACE_PKG_SV
`define MSP_TRACE_PKG_SV

`ifdef MSP_TRACE_CYCLE_EN
`define MSP_TRACE_ENTRY_W(cw) (33 + (cw))
`else
`define MSP_TRACE_ENTRY_W(cw) (33 + 0 * (cw))
`endif

package msp_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  // Entry layout, LSB upwards: op, pc, irq flag, then optional cycle count
  localparam int OP_LSB  = 0;
  localparam int PC_LSB  = 16;
  localparam int IRQ_BIT = 32;
  localparam int CYC_LSB = 33;

endpackage

`endif

// File: rtl/msp_trace_ram.sv
// Trace storage: register array with synchronous write and asynchronous read, no reset.
module msp_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             mclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge mclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msp_inst_trace.sv
// Instruction trace buffer with PC-match trigger, post-trigger depth and valid/ready read-out.
// Define MSP_TRACE_CYCLE_EN to record cycles since the previous decode in each entry.
module msp_inst_trace
  import msp_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  parameter int POST_W = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int ENTRY_W = `MSP_TRACE_ENTRY_W(CYC_W)
) (
  input  logic               mclk,
  input  logic               puc,
  input  logic               decode,
  input  logic [15:0]        pc,
  input  logic [15:0]        ir,
  input  logic               irq_detect,
  input  logic [3:0]         irq_num,
  input  logic               arm,
  input  logic               stop,
  input  logic               trig_en,
  input  logic [15:0]        trig_pc,
  input  logic [POST_W-1:0]  post_cnt,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        count,
  output logic [1:0]         state,
  output logic [31:0]        inst_number
);

  trace_state_e        state_q, state_d;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count_q;
  logic [POST_W-1:0]   post_rem;
  logic [31:0]         inst_cnt;
  logic [15:0]         op;
  logic [ENTRY_W-1:0]  wr_entry;
  logic                capture, trig_hit, pop, full;

  assign op       = irq_detect ? {12'h000, irq_num} : ir;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign capture  = decode && !arm && (state_q == ST_ARMED || state_q == ST_POST);
  assign trig_hit = capture && state_q == ST_ARMED && trig_en && (pc == trig_pc);
  assign pop      = !arm && rd_valid && rd_ready;

`ifdef MSP_TRACE_CYCLE_EN
  logic [CYC_W-1:0] cyc_cnt;

  always_ff @(posedge mclk or posedge puc) begin
    if (puc)                cyc_cnt <= '0;
    else if (decode)        cyc_cnt <= CYC_W'(1);
    else if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CYC_W'(1);
  end

  assign wr_entry = {cyc_cnt, irq_detect, pc, op};
`else
  assign wr_entry = {irq_detect, pc, op};
`endif

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // stop wins over the trigger; the decode in that cycle is still captured
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (stop)          state_d = ST_FROZEN;
          else if (trig_hit) state_d = (post_cnt == '0) ? ST_FROZEN : ST_POST;
        end
        ST_POST: begin
          if (stop)                                 state_d = ST_FROZEN;
          else if (decode && post_rem == POST_W'(1)) state_d = ST_FROZEN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // On overflow the oldest entry is dropped by dragging rd_ptr along with wr_ptr
  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      post_rem <= '0;
      inst_cnt <= '0;
    end else begin
      if (decode) inst_cnt <= inst_cnt + 32'd1;
      if (arm) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) rd_ptr  <= rd_ptr + AW'(1);
        else      count_q <= count_q + (AW+1)'(1);
      end else if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_q <= count_q - (AW+1)'(1);
      end
      if (trig_hit)                          post_rem <= post_cnt;
      else if (capture && state_q == ST_POST) post_rem <= post_rem - POST_W'(1);
    end
  end

  msp_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .mclk  (mclk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign rd_valid    = (state_q == ST_FROZEN) && (count_q != '0);
  assign count       = count_q;
  assign state       = state_q;
  assign inst_number = inst_cnt;

endmodule

// File: tb/tb_msp_inst_trace.sv
// Directed self-checking bench for msp_inst_trace (DEPTH 16); cycle-field checks need MSP_TRACE_CYCLE_EN.
module tb_msp_inst_trace;
  import msp_trace_pkg::*;

  localparam int EW = `MSP_TRACE_ENTRY_W(16);

  logic          mclk = 1'b0;
  logic          puc, decode, irq_detect, arm, stop, trig_en, rd_ready;
  logic [15:0]   pc, ir, trig_pc;
  logic [3:0]    irq_num;
  logic [7:0]    post_cnt;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [4:0]    count;
  logic [1:0]    state;
  logic [31:0]   inst_number;

  int checks   = 0;
  int failures = 0;
  int exp_inst = 0;

  msp_inst_trace #(.DEPTH(16), .CYC_W(16), .POST_W(8)) dut (
    .mclk(mclk), .puc(puc), .decode(decode), .pc(pc), .ir(ir),
    .irq_detect(irq_detect), .irq_num(irq_num), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .state(state), .inst_number(inst_number)
  );

  always #5 mclk = ~mclk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_decode(input logic [15:0] p, input logic [15:0] i,
                           input logic irq, input logic [3:0] num);
    decode = 1'b1; pc = p; ir = i; irq_detect = irq; irq_num = num;
    tick();
    decode = 1'b0; irq_detect = 1'b0;
    exp_inst++;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset();
    puc = 1'b1; tick(); tick();
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got %b expected 0", rd_valid); end
    checks++; if (inst_number !== 32'd0) begin failures++; $display("[TB] FAIL reset_inst got %0d expected 0", inst_number); end
    puc = 1'b0; exp_inst = 0; tick();
    pulse_stop();
    do_decode(16'h1234, 16'h4303, 1'b0, 4'h0);
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL idle_stop got %0d expected 0", state); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL idle_nocap got %0d expected 0", count); end
    checks++; if (inst_number !== 32'(exp_inst)) begin failures++; $display("[TB] FAIL idle_inst got %0d expected %0d", inst_number, exp_inst); end
  endtask

  task automatic test_basic();
    pulse_arm();
    for (int i = 0; i < 5; i++) do_decode(16'hF000 + 16'(2*i), 16'h4303, 1'b0, 4'h0);
    checks++; if (count !== 5'd5) begin failures++; $display("[TB] FAIL basic_count got %0d expected 5", count); end
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL basic_armed got %0d expected 1", state); end
    checks++; if (inst_number !== 32'(exp_inst)) begin failures++; $display("[TB] FAIL basic_inst got %0d expected %0d", inst_number, exp_inst); end
    pulse_stop();
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL basic_frozen got %0d expected 3", state); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid%0d got %b expected 1", i, rd_valid); end
      checks++; if (rd_data[31:0] !== {16'hF000 + 16'(2*i), 16'h4303}) begin failures++; $display("[TB] FAIL basic_pop%0d got %h expected %h", i, rd_data[31:0], {16'hF000 + 16'(2*i), 16'h4303}); end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drained got %b expected 0", rd_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL basic_count0 got %0d expected 0", count); end
  endtask

  task automatic test_overflow();
    pulse_arm();
    for (int i = 0; i < 20; i++) do_decode(16'hE000 + 16'(2*i), 16'h1000 + 16'(i), 1'b0, 4'h0);
    pulse_stop();
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count got %0d expected 16", count); end
    rd_ready = 1'b1;
    for (int i = 4; i < 20; i++) begin
      checks++; if (rd_data[31:16] !== 16'hE000 + 16'(2*i)) begin failures++; $display("[TB] FAIL ovf_pop%0d got %h expected %h", i, rd_data[31:16], 16'hE000 + 16'(2*i)); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained got %b expected 0", rd_valid); end
  endtask

  task automatic test_trigger();
    pulse_arm();
    trig_en = 1'b1; trig_pc = 16'hF010; post_cnt = 8'd3;
    for (int i = 0; i <= 16; i++) begin
      do_decode(16'hF000 + 16'(2*i), 16'h4303, 1'b0, 4'h0);
      if (i == 8) begin
        checks++; if (state !== 2'd2) begin failures++; $display("[TB] FAIL trig_post got %0d expected 2", state); end
      end
      if (i == 11) begin
        checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL trig_frozen got %0d expected 3", state); end
      end
    end
    checks++; if (count !== 5'd12) begin failures++; $display("[TB] FAIL trig_count got %0d expected 12", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (rd_data[31:16] !== 16'hF000 + 16'(2*i)) begin failures++; $display("[TB] FAIL trig_pop%0d got %h expected %h", i, rd_data[31:16], 16'hF000 + 16'(2*i)); end
      tick();
    end
    rd_ready = 1'b0;
    pulse_arm();
    post_cnt = 8'd0; trig_pc = 16'hC000;
    do_decode(16'hB000, 16'h4303, 1'b0, 4'h0);
    do_decode(16'hC000, 16'h4303, 1'b0, 4'h0);
    do_decode(16'hC002, 16'h4303, 1'b0, 4'h0);
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL trig0_state got %0d expected 3", state); end
    checks++; if (count !== 5'd2) begin failures++; $display("[TB] FAIL trig0_count got %0d expected 2", count); end
    trig_en = 1'b0;
  endtask

  task automatic test_irq();
    pulse_arm();
    do_decode(16'hFFFC, 16'h1234, 1'b1, 4'hE);
    pulse_stop();
    checks++; if (rd_data[32:0] !== {1'b1, 16'hFFFC, 16'h000E}) begin failures++; $display("[TB] FAIL irq_entry got %h expected %h", rd_data[32:0], {1'b1, 16'hFFFC, 16'h000E}); end
  endtask

  task automatic test_arm_decode();
    arm = 1'b1; decode = 1'b1; pc = 16'hA000; ir = 16'h4303;
    tick();
    arm = 1'b0; decode = 1'b0; exp_inst++;
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL armdec_count got %0d expected 0", count); end
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL armdec_state got %0d expected 1", state); end
    checks++; if (inst_number !== 32'(exp_inst)) begin failures++; $display("[TB] FAIL armdec_inst got %0d expected %0d", inst_number, exp_inst); end
  endtask

  task automatic test_puc_post();
    trig_en = 1'b1; trig_pc = 16'hD000; post_cnt = 8'd5;
    do_decode(16'hD000, 16'h4303, 1'b0, 4'h0);
    checks++; if (state !== 2'd2) begin failures++; $display("[TB] FAIL puc_pre got %0d expected 2", state); end
    #2 puc = 1'b1; #1;
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL puc_state got %0d expected 0", state); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL puc_valid got %b expected 0", rd_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL puc_count got %0d expected 0", count); end
    tick();
    puc = 1'b0; trig_en = 1'b0; exp_inst = 0;
  endtask

`ifdef MSP_TRACE_CYCLE_EN
  task automatic test_cycle();
    pulse_arm();
    do_decode(16'h9000, 16'h4303, 1'b0, 4'h0);
    tick(); tick();
    do_decode(16'h9002, 16'h4303, 1'b0, 4'h0);
    do_decode(16'h9004, 16'h4303, 1'b0, 4'h0);
    repeat (70000) @(posedge mclk);
    #1;
    do_decode(16'h9006, 16'h4303, 1'b0, 4'h0);
    pulse_stop();
    rd_ready = 1'b1; tick();
    checks++; if (rd_data[48:33] !== 16'd3) begin failures++; $display("[TB] FAIL cyc_gap got %0d expected 3", rd_data[48:33]); end
    tick();
    checks++; if (rd_data[48:33] !== 16'd1) begin failures++; $display("[TB] FAIL cyc_b2b got %0d expected 1", rd_data[48:33]); end
    tick();
    checks++; if (rd_data[48:33] !== 16'hFFFF) begin failures++; $display("[TB] FAIL cyc_sat got %h expected ffff", rd_data[48:33]); end
    rd_ready = 1'b0;
  endtask
`endif

  initial begin
    puc = 1'b1; decode = 1'b0; irq_detect = 1'b0; arm = 1'b0; stop = 1'b0;
    trig_en = 1'b0; rd_ready = 1'b0; pc = '0; ir = '0; trig_pc = '0;
    irq_num = '0; post_cnt = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_trigger();
    test_irq();
    test_arm_decode();
    test_puc_post();
`ifdef MSP_TRACE_CYCLE_EN
    test_cycle();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
